// File: rtl/key_dir_if.sv
// Signal bundle between the direction-key front end, the board pins and the game core.
interface key_dir_if;
  logic [3:0]  key_raw;
  logic        lose;
  logic [3:0]  ready_from;
  logic [1:0]  dir_code;
  logic [15:0] move_cnt;

  modport master (output key_raw, output lose, input ready_from, input dir_code, input move_cnt);
  modport slave  (input key_raw, input lose, output ready_from, output dir_code, output move_cnt);
endinterface

// File: rtl/key_dir_capture.sv
// Direction push-button front end: synchronise, debounce, and turn each press into one
// single-cycle one-hot move pulse, with game-over suppression and a saturating move count.
module key_dir_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit PRESSED_LEVEL   = 1'b0
) (
  input logic      clk,
  input logic      rst,
  key_dir_if.slave bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FIRE     = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  logic [3:0]       pressed;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       press_evt;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       state;
  logic [1:0]       sel;
  logic [1:0]       first_idx;
  logic [3:0]       ready_q;
  logic [1:0]       dir_q;
  logic [15:0]      move_cnt_q;

  assign pressed   = PRESSED_LEVEL ? bus.key_raw : ~bus.key_raw;
  assign press_evt = stable & ~stable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 4'b0000;
      sync2    <= 4'b0000;
      stable_d <= 4'b0000;
    end else begin
      sync1    <= pressed;
      sync2    <= sync1;
      stable_d <= stable;
    end
  end

  // Any cycle where the synchronised level matches the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press_evt[i]) first_idx = 2'(i);
    end
  end

  // A press seen while lost is swallowed but still has to be released before the next move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= 2'd0;
      ready_q    <= 4'b0000;
      dir_q      <= 2'd0;
      move_cnt_q <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (press_evt != 4'b0000) begin
            if (!bus.lose) begin
              state   <= FIRE;
              sel     <= first_idx;
              ready_q <= 4'b0001 << first_idx;
            end else begin
              state <= WAIT_REL;
            end
          end
        end
        FIRE: begin
          ready_q <= 4'b0000;
          dir_q   <= sel;
          if (move_cnt_q != 16'hFFFF) move_cnt_q <= move_cnt_q + 16'd1;
          state   <= WAIT_REL;
        end
        WAIT_REL: begin
          if (stable == 4'b0000) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.ready_from = ready_q;
  assign bus.dir_code   = dir_q;
  assign bus.move_cnt   = move_cnt_q;

endmodule

// File: tb/tb_key_dir_capture.sv
// Directed and randomised bench for key_dir_capture, checked against a sample-window reference model.
module tb_key_dir_capture;

  localparam int D = 4;

  logic clk;
  logic rst;
  key_dir_if kif();

  key_dir_capture #(.DEBOUNCE_CYCLES(D), .PRESSED_LEVEL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int edge_idx;
  int obs_pulses;
  int obs_last_edge;
  logic [3:0] obs_last_val;

  // Reference model: a key's accepted level flips once its last D synchronised samples all agree.
  logic [3:0]  samp_q[$];
  logic [3:0]  m_stable;
  logic [3:0]  m_stable_prev;
  logic [3:0]  m_ready;
  logic [1:0]  m_dir;
  logic [1:0]  m_sel;
  logic [15:0] m_cnt;
  bit          m_armed;
  bit          m_fire;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i <= D; i++) samp_q.push_back(4'b0000);
    m_stable      = 4'b0000;
    m_stable_prev = 4'b0000;
    m_ready       = 4'b0000;
    m_dir         = 2'd0;
    m_sel         = 2'd0;
    m_cnt         = 16'd0;
    m_armed       = 1'b1;
    m_fire        = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] pr, input logic lz);
    logic [3:0] evt;
    logic [3:0] nxt;
    logic [3:0] ref_s;
    bit         same;
    int         n;
    evt     = m_stable & ~m_stable_prev;
    m_ready = 4'b0000;
    if (m_fire) begin
      m_dir  = m_sel;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_fire = 1'b0;
    end else if (!m_armed) begin
      if (m_stable == 4'b0000) m_armed = 1'b1;
    end else if (evt != 4'b0000) begin
      m_armed = 1'b0;
      if (!lz) begin
        m_fire  = 1'b1;
        m_sel   = lowest(evt);
        m_ready = 4'b0001 << m_sel;
      end
    end
    n     = samp_q.size();
    ref_s = samp_q[n-2];
    nxt   = m_stable;
    for (int k = 0; k < 4; k++) begin
      same = 1'b1;
      for (int j = n - 1 - D; j <= n - 2; j++) begin
        if (samp_q[j][k] != ref_s[k]) same = 1'b0;
      end
      if (same && ref_s[k] != m_stable[k]) nxt[k] = ref_s[k];
    end
    m_stable_prev = m_stable;
    m_stable      = nxt;
    samp_q.push_back(pr);
    while (samp_q.size() > D + 1) void'(samp_q.pop_front());
  endtask

  task automatic tick();
    logic [3:0] pr;
    logic       lz;
    pr = ~kif.key_raw;
    lz = kif.lose;
    @(posedge clk);
    model_edge(pr, lz);
    edge_idx++;
    @(negedge clk);
    if (kif.ready_from != 4'b0000) begin
      obs_pulses++;
      obs_last_edge = edge_idx;
      obs_last_val  = kif.ready_from;
    end
    chk("ready_from", 16'(kif.ready_from), 16'(m_ready));
    chk("dir_code",   16'(kif.dir_code),   16'(m_dir));
    chk("move_cnt",   kif.move_cnt,        m_cnt);
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int cycles);
    kif.key_raw = ~mask;
    repeat (cycles) tick();
  endtask

  task automatic clear_obs();
    obs_pulses    = 0;
    obs_last_edge = -1;
    obs_last_val  = 4'b0000;
    edge_idx      = -1;
  endtask

  task automatic checkOutput(input string tag, input int pulses, input logic [3:0] val,
                             input logic [15:0] cnt);
    chk({tag, "_pulses"}, 16'(obs_pulses), 16'(pulses));
    if (pulses != 0) chk({tag, "_val"}, 16'(obs_last_val), 16'(val));
    chk({tag, "_cnt"}, kif.move_cnt, cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 16'(kif.ready_from), 16'd0);
    chk({tag, "_dir"},   16'(kif.dir_code),   16'd0);
    chk({tag, "_cnt"},   kif.move_cnt,        16'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    clear_obs();
  endtask

  initial begin
    int guard;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    kif.key_raw = 4'hF;
    kif.lose    = 1'b0;
    model_reset();
    clear_obs();
    #13;
    check_zero("reset");
    release_reset();

    // Clean press of key 2: pulse expected D+2 edges after the first sampled edge.
    applyStimulus(4'b0000, 5);
    clear_obs();
    applyStimulus(4'b0100, 20);
    chk("t1_edge", 16'(obs_last_edge), 16'(D + 2));
    chk("t1_dir", 16'(kif.dir_code), 16'd2);
    applyStimulus(4'b0000, 12);
    checkOutput("t1", 1, 4'b0100, 16'd1);

    // Key 0 bounce, then held.
    clear_obs();
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0000, 1);
    chk("t2_nopulse", 16'(obs_pulses), 16'd0);
    edge_idx = -1;
    applyStimulus(4'b0001, 15);
    chk("t2_edge", 16'(obs_last_edge), 16'(D + 2));
    applyStimulus(4'b0000, 12);
    checkOutput("t2", 1, 4'b0001, 16'd2);

    // Simultaneous keys 1 and 3; key 3 re-press while key 1 held is ignored.
    clear_obs();
    applyStimulus(4'b1010, 12);
    checkOutput("t3a", 1, 4'b0010, 16'd3);
    chk("t3a_dir", 16'(kif.dir_code), 16'd1);
    applyStimulus(4'b0010, 10);
    applyStimulus(4'b1010, 10);
    checkOutput("t3b", 1, 4'b0010, 16'd3);
    applyStimulus(4'b0000, 12);
    applyStimulus(4'b1000, 12);
    applyStimulus(4'b0000, 12);
    checkOutput("t3c", 2, 4'b1000, 16'd4);

    // Game lost: press swallowed; lose dropping while held does not fire either.
    clear_obs();
    kif.lose = 1'b1;
    applyStimulus(4'b0001, 15);
    applyStimulus(4'b0000, 12);
    applyStimulus(4'b0100, 10);
    kif.lose = 1'b0;
    applyStimulus(4'b0100, 10);
    applyStimulus(4'b0000, 12);
    checkOutput("t4a", 0, 4'b0000, 16'd4);
    applyStimulus(4'b0001, 12);
    applyStimulus(4'b0000, 12);
    checkOutput("t4b", 1, 4'b0001, 16'd5);

    // Saturation from a preloaded count.
    force dut.move_cnt_q = 16'hFFFE;
    #1;
    release dut.move_cnt_q;
    m_cnt = 16'hFFFE;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'b1000, 10);
      applyStimulus(4'b0000, 10);
    end
    chk("t5_sat", kif.move_cnt, 16'hFFFF);

    // Reset mid-debounce with the key still held afterwards.
    applyStimulus(4'b0100, 3);
    rst = 1'b0;
    #1;
    check_zero("t6a_rst");
    @(posedge clk);
    release_reset();
    applyStimulus(4'b0100, 12);
    chk("t6a_edge", 16'(obs_last_edge), 16'(D + 2));
    applyStimulus(4'b0000, 12);
    checkOutput("t6a", 1, 4'b0100, 16'd1);

    // Reset during the pulse cycle.
    guard = 0;
    kif.key_raw = ~4'b0010;
    while (m_ready == 4'b0000 && guard < 20) begin
      tick();
      guard++;
    end
    chk("t6b_reached", 16'(guard < 20), 16'd1);
    rst = 1'b0;
    #1;
    check_zero("t6b_rst");
    @(posedge clk);
    release_reset();
    applyStimulus(4'b0010, 12);
    chk("t6b_edge", 16'(obs_last_edge), 16'(D + 2));
    applyStimulus(4'b0000, 12);
    checkOutput("t6b", 1, 4'b0010, 16'd1);

    // Random key patterns, holds and lose flag against the model.
    for (int s = 0; s < 120; s++) begin
      kif.lose = ($urandom_range(0, 7) == 0);
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 10));
      if ($urandom_range(0, 3) == 0) applyStimulus(4'b0000, $urandom_range(6, 12));
    end
    kif.lose = 1'b0;
    applyStimulus(4'b0000, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_dir_capture.md
Name: key_dir_capture

Overview:
- Front-end for the four direction push-buttons of the 2048 board; sits directly upstream of the buzzer and the game core.
- Synchronises and debounces the raw button pins.
- Converts each debounced press into exactly one single-cycle one-hot pulse on ready_from, giving one move per physical press.
- Suppresses moves after the game is lost and keeps a saturating count of accepted moves.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (20 ms at 50 MHz); legal range >= 2
PRESSED_LEVEL, 0, raw pin level meaning "pressed" (0 = active-low buttons)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-low reset; all state clears while low
key_raw  input  4  raw button pins, bit0 up, bit1 down, bit2 left, bit3 right; asynchronous to clk
lose  input  1  game-over flag from game core, synchronous to clk
ready_from  output  4  one-hot move pulse, high for exactly one cycle per accepted press
dir_code  output  2  index of the last accepted direction (0..3)
move_cnt  output  16  number of accepted moves, saturating

Behaviour:
- Reset (rst low, asynchronous) clears:
  - all registers, including sync, stable and counters;
  - ready_from = 4'b0000, dir_code = 2'd0, move_cnt = 16'd0;
  - FSM to IDLE.
- Normalisation: pressed_i = (key_raw[i] == PRESSED_LEVEL).
- Synchronisation: two flops per key, reset value 0 (not pressed).
- Debounce, per key:
  - One counter cnt_i, width ceil(log2(DEBOUNCE_CYCLES)).
  - If sync2_i == stable_i: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: stable_i <= sync2_i and cnt_i <= 0.
  - Else cnt_i <= cnt_i + 1.
  - Any single-cycle bounce back to the stable level restarts the count.
- press_evt = stable & ~stable_d, where stable_d is stable delayed by one cycle (reset 0).
- FSM states:
  - IDLE: no press_evt -> stay. press_evt != 0 and lose == 0 -> FIRE, latching sel = lowest set index of press_evt. press_evt != 0 and lose == 1 -> WAIT_REL (press swallowed, no pulse, no count).
  - FIRE, one cycle:
    - ready_from is the registered output = 1 << sel; it is 0 in every other state.
    - dir_code <= sel.
    - move_cnt <= move_cnt + 1, held at 16'hFFFF once reached.
    - Unconditionally -> WAIT_REL.
  - WAIT_REL: stay while stable != 0; -> IDLE in the cycle after stable == 4'b0000. press_evt here is ignored, including a second key pressed while the first is held.
- Latency: raw press first sampled at edge E0 with no bounce -> stable set after edge E(D+1) -> ready_from high from edge E(D+2) to E(D+3), where D = DEBOUNCE_CYCLES.
- Simultaneous presses debounced in the same cycle: lowest index wins; one pulse only, and the other keys are not queued.
- lose rising while a key is held has no effect on a pulse already in FIRE. lose falling while a key is held does not fire; a fresh press after full release is required.
- ready_from is never multi-hot and never asserted in consecutive cycles.
- At least one IDLE cycle separates two pulses.
- dir_code holds its value between pulses.

Test Plan:
- D=4, clean press of key_raw[2] (driven to 0) from E0, held 20 cycles, then released -> ready_from = 4'b0100 for exactly one cycle, spanning E6..E7; dir_code = 2; move_cnt = 1; no further pulse after release.
- D=4, key0 bounces 1,0,1,0,1 on alternate cycles, then held steady -> no pulse during bounce; single 4'b0001 pulse D+2 edges after the last transition.
- D=4, keys 1 and 3 pressed in the same cycle -> one pulse 4'b0010, dir_code = 1; with key1 still held, releasing and re-pressing key3 gives no pulse; after all keys release, a new key3 press gives 4'b1000.
- lose = 1, press and release key0 -> no pulse and move_cnt unchanged; lose = 0 then press key0 again -> pulse 4'b0001.
- Preload move_cnt to 16'hFFFE by forced pre-state or by pressing 65534 times with D=2 -> two more presses leave move_cnt = 16'hFFFF.
- Assert rst low mid-debounce and separately during the FIRE cycle -> ready_from drops to 0 immediately, before the next edge; all outputs are zero; after release of rst a key already held produces a pulse only after a full D+2 debounce from the first sampled edge.
